// File: rtl/imem_responder_pkg.sv
// Shared constants and helpers for the instruction-memory responder slice.
package imem_responder_pkg;

  localparam logic FETCH_OK    = 1'b0;
  localparam logic FETCH_FAULT = 1'b1;

  function automatic int clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Response FIFO must hold every request that can be in flight in the read pipeline plus one.
  function automatic int fifoDepth(input int lat);
    return lat + 1;
  endfunction

endpackage

// File: rtl/imem_responder_resp_fifo.sv
// Circular response FIFO of depth F; flush may coincide with a push, which becomes the sole entry.
module resp_fifo
  import imem_responder_pkg::*;
#(
  parameter int W  = 33,
  parameter int F  = 2,
  localparam int PW = clog2(F),
  localparam int CW = clog2(F + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wrData,
  output logic [W-1:0]  rdData,
  output logic [CW-1:0] count
);

  logic [W-1:0]  store [F];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(F - 1)) ? PW'(0) : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= push ? PW'(1) : PW'(0);
      count <= push ? CW'(1) : CW'(0);
    end else begin
      if (push) wrPtr <= bump(wrPtr);
      if (pop)  rdPtr <= bump(rdPtr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) store[flush ? PW'(0) : wrPtr] <= wrData;
  end

  assign rdData = store[rdPtr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: in-order word fetch with fixed read latency, flush and a loader port.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int          W     = 32,
  parameter int          DEPTH = 1024,
  parameter int          LAT   = 1,
  parameter logic [W-1:0] BASE = 32'h00000000,
  localparam int AW = clog2(DEPTH),
  localparam int F  = fifoDepth(LAT),
  localparam int CW = clog2(F + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [W-1:0]  req_addr,
  output logic          req_ready,
  output logic          rsp_valid,
  output logic [W-1:0]  rsp_data,
  output logic          rsp_err,
  input  logic          rsp_ready,
  input  logic          flush,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data
);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] outCnt;
  logic [CW-1:0] fifoCount;
  logic [W-1:0]  off;
  logic          fault;
  logic [AW-1:0] wordIdx;
  logic          accept;
  logic          pop;
  logic          rspAvail;
  logic          pushVld;
  logic [W:0]    pushEntry;
  logic [W:0]    entry_p0;
  logic [W:0]    head;

  // Unsigned offset: an address below BASE wraps to a huge offset and faults.
  assign off     = req_addr - BASE;
  assign fault   = (req_addr[1:0] != 2'b00) || (off >= W'(DEPTH * 4));
  assign wordIdx = off[AW+1:2];

  assign req_ready = (outCnt < CW'(F)) || flush;
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (ld_we && !rst) mem[ld_addr] <= ld_data;
  end

  // Stage p0: array read at the accept edge (old data on a same-word load).
  assign entry_p0 = {(fault ? FETCH_FAULT : FETCH_OK), (fault ? {W{1'b0}} : mem[wordIdx])};

  generate
    if (LAT == 1) begin : gDirect
      assign pushVld   = accept;
      assign pushEntry = entry_p0;
    end else begin : gPipe
      logic [W:0] entPipe [LAT-1];
      logic       vldPipe [LAT-1];

      // Stages p1..p(LAT-1); the request accepted during a flush survives it.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < LAT - 1; s++) vldPipe[s] <= 1'b0;
        end else begin
          vldPipe[0] <= accept;
          for (int s = 1; s < LAT - 1; s++) vldPipe[s] <= vldPipe[s-1] && !flush;
        end
      end

      always_ff @(posedge clk) begin
        entPipe[0] <= entry_p0;
        for (int s = 1; s < LAT - 1; s++) entPipe[s] <= entPipe[s-1];
      end

      assign pushVld   = vldPipe[LAT-2] && !flush;
      assign pushEntry = entPipe[LAT-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)        outCnt <= '0;
    else if (flush) outCnt <= CW'(accept);
    else            outCnt <= outCnt + CW'(accept) - CW'(pop);
  end

  resp_fifo #(.W(W + 1), .F(F)) uFifo (
    .clk    (clk),
    .rst    (rst),
    .push   (pushVld),
    .pop    (pop),
    .flush  (flush),
    .wrData (pushEntry),
    .rdData (head),
    .count  (fifoCount)
  );

  // Outputs are masked when empty so unwritten FIFO slots never reach the consumer.
  assign rspAvail  = (fifoCount != '0);
  assign rsp_valid = rspAvail && !flush;
  assign rsp_data  = rspAvail ? head[W-1:0] : '0;
  assign rsp_err   = rspAvail && head[W];

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench: two responders (LAT=1 and LAT=2) share stimulus; each has its own reference queue.
module tb_imem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic [31:0] reqAddr;
  logic        rspReady;
  logic        flush;
  logic        ldWe;
  logic [9:0]  ldAddr;
  logic [31:0] ldData;

  logic        reqReady [2];
  logic        rspValid [2];
  logic [31:0] rspData  [2];
  logic        rspErr   [2];

  always #5 clk = ~clk;

  imem_responder #(.W(32), .DEPTH(DEPTH), .LAT(1), .BASE(32'h0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_addr(reqAddr), .req_ready(reqReady[0]),
    .rsp_valid(rspValid[0]), .rsp_data(rspData[0]), .rsp_err(rspErr[0]), .rsp_ready(rspReady),
    .flush(flush), .ld_we(ldWe), .ld_addr(ldAddr), .ld_data(ldData));

  imem_responder #(.W(32), .DEPTH(DEPTH), .LAT(2), .BASE(32'h0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_addr(reqAddr), .req_ready(reqReady[1]),
    .rsp_valid(rspValid[1]), .rsp_data(rspData[1]), .rsp_err(rspErr[1]), .rsp_ready(rspReady),
    .flush(flush), .ld_we(ldWe), .ld_addr(ldAddr), .ld_data(ldData));

  // Reference model: word array plus, per instance, an ordered list of expected responses with due cycle.
  logic [31:0] mMem  [DEPTH];
  logic [31:0] eData [2][8];
  logic        eErr  [2][8];
  int          eDue  [2][8];
  int          eCnt  [2];
  int          cyc = 0;
  int          nVec = 0;
  int          nBad = 0;
  bit          armed = 1'b0;
  bit          postRst = 1'b0;

  int          fDepth;
  bit          expRdy, expVld, acc, popM, aErr;
  logic [31:0] aData;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s dut%0d cycle %0d: got %h want %h", name, inst, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        fDepth = i + 2;
        expRdy = (eCnt[i] < fDepth) || flush;
        expVld = !flush && (eCnt[i] > 0) && (eDue[i][0] <= cyc);
        chk("req_ready", i, 32'(reqReady[i]), 32'(expRdy));
        chk("rsp_valid", i, 32'(rspValid[i]), 32'(expVld));
        if (expVld) begin
          chk("rsp_data", i, rspData[i], eData[i][0]);
          chk("rsp_err", i, 32'(rspErr[i]), 32'(eErr[i][0]));
        end
        if (postRst && !rst) begin
          chk("rst_data", i, rspData[i], 32'h0);
          chk("rst_err", i, 32'(rspErr[i]), 32'h0);
        end
        acc  = reqValid && expRdy;
        popM = rspReady && expVld;
        if (rst) begin
          eCnt[i] = 0;
        end else begin
          if (flush) begin
            eCnt[i] = 0;
          end else if (popM) begin
            for (int k = 0; k < 7; k++) begin
              eData[i][k] = eData[i][k+1];
              eErr[i][k]  = eErr[i][k+1];
              eDue[i][k]  = eDue[i][k+1];
            end
            eCnt[i]--;
          end
          if (acc) begin
            aErr  = (reqAddr[1:0] != 2'b00) || (reqAddr >= 32'(DEPTH * 4));
            aData = aErr ? 32'h0 : mMem[reqAddr[11:2]];
            eData[i][eCnt[i]] = aData;
            eErr[i][eCnt[i]]  = aErr;
            eDue[i][eCnt[i]]  = cyc + i + 1;
            eCnt[i]++;
          end
        end
      end
      if (!rst && ldWe) mMem[ldAddr] = ldData;
    end else if (rst) begin
      eCnt[0] = 0;
      eCnt[1] = 0;
      armed = 1'b1;
    end
    postRst = rst;
    cyc++;
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic rr, input logic fl);
    reqValid = v;
    reqAddr  = a;
    rspReady = rr;
    flush    = fl;
    @(posedge clk);
    #1;
    ldWe = 1'b0;
    rst  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  logic [31:0] prog [4];
  logic [31:0] rAddr;
  int          r;

  initial begin
    prog[0] = 32'h00000013; prog[1] = 32'h00100093;
    prog[2] = 32'h00200113; prog[3] = 32'h00300193;
    rst = 1'b1; reqValid = 1'b0; reqAddr = '0; rspReady = 1'b0; flush = 1'b0;
    ldWe = 1'b0; ldAddr = '0; ldData = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < DEPTH; k++) begin
      ldWe = 1'b1; ldAddr = 10'(k); ldData = (k < 4) ? prog[k] : $urandom;
      drive(1'b0, 32'h0, 1'b1, 1'b0);
    end

    // Back-to-back fetch
    for (int k = 0; k < 4; k++) drive(1'b1, 32'(k * 4), 1'b1, 1'b0);
    idle(3);

    // Backpressure: last address held until accepted
    for (int k = 0; k < 6; k++) drive(1'b1, 32'((k < 3 ? k : 3) * 4), 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b1, 1'b0);
    idle(5);

    // Faults between valid fetches
    drive(1'b1, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h6, 1'b1, 1'b0);
    drive(1'b1, 32'h4, 1'b1, 1'b0);
    drive(1'b1, 32'h1000, 1'b1, 1'b0);
    drive(1'b1, 32'h8, 1'b1, 1'b0);
    idle(4);

    // Flush with redirect to addr 8
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h8, 1'b1, 1'b1);
    idle(4);

    // Reset with full FIFO and a load that must be dropped
    for (int k = 0; k < 4; k++) drive(1'b1, 32'h0, 1'b0, 1'b0);
    rst = 1'b1; ldWe = 1'b1; ldAddr = 10'd1; ldData = 32'hBAD0BAD0;
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h4, 1'b1, 1'b0);
    idle(4);

    // Loader collision on word 0
    ldWe = 1'b1; ldAddr = 10'd0; ldData = 32'hDEADBEEF;
    drive(1'b1, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h0, 1'b1, 1'b0);
    idle(4);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      rAddr = {$urandom_range(0, 1023), 2'($urandom_range(1, 3))} & 32'hFFF;
      else if (r == 1) rAddr = 32'h1000 + ($urandom_range(0, 255) << 2);
      else             rAddr = 32'($urandom_range(0, 63)) << 2;
      ldWe   = ($urandom_range(0, 7) == 0);
      ldAddr = 10'($urandom_range(0, 63));
      ldData = $urandom;
      rst    = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) != 0, rAddr, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory end of the fetch interface that issues the PC each cycle.
- Accepts word fetch requests over a valid/ready handshake and reads a synchronous word array.
- Returns instruction words in order, with fixed read latency and a small response FIFO that absorbs decode stalls.
- A flush input discards every in-flight response when the core redirects the PC (branch, jump or trap).

Parameters:
- W, 32, data and address width.
- DEPTH, 1024, number of W-bit words in the array; power of two.
- LAT, 1, read pipeline stages from request acceptance to FIFO entry; LAT >= 1.
- BASE, 32'h00000000, byte address of word 0; DEPTH*4-aligned.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_addr  in  W  byte address of the requested instruction (PC).
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- rsp_valid  out  1  head response available.
- rsp_data  out  W  instruction word; 0 when rsp_err=1.
- rsp_err  out  1  fetch fault: misaligned or out-of-range address.
- rsp_ready  in  1  consumer pops the head response when high together with rsp_valid.
- flush  in  1  discard all outstanding responses (PC redirect).
- ld_we  in  1  loader write enable.
- ld_addr  in  log2(DEPTH)  loader word index.
- ld_data  in  W  loader write data.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Clears pipeline valids, FIFO pointers and the outstanding counter.
  - The array is not cleared.
  - After reset: rsp_valid=0, rsp_err=0, rsp_data=0, and req_ready=1 from the first cycle after rst deasserts.
  - rst overrides flush, requests and loads in the same cycle; a load in a reset cycle is dropped.
- Capacity and accept rule:
  - FIFO depth F=LAT+1.
  - The outstanding count (pipeline + FIFO occupancy) is at most F.
  - req_ready = (outstanding < F) OR flush. The check is combinational and has no dependence on rsp_ready.
- Outstanding update per cycle: +1 on accept, -1 on pop.
  - Simultaneous accept and pop leaves the count unchanged.
- Address decode on accept, with off = req_addr - BASE:
  - err = (req_addr[1:0] != 0) OR (off >= DEPTH*4), using unsigned W-bit arithmetic, so an address below BASE wraps and faults.
  - Word index = off[log2(DEPTH)+1:2].
- Latency and throughput:
  - A request accepted in cycle t enters the FIFO at the end of cycle t+LAT-1.
  - rsp_valid is high in cycle t+LAT when the FIFO was empty.
  - Sustained throughput is 1 word/cycle while rsp_ready=1.
- Response ordering: strictly in acceptance order; faulting requests occupy slots like normal ones.
- FIFO wrap-around: circular pointers with wrap at F.
  - Full is indicated by the outstanding count, not by pointer equality.
- Stall: with rsp_ready=0 the head is held stable (rsp_valid, rsp_data, rsp_err unchanged) until popped or flushed.
- Flush:
  - In the flush cycle: all pipeline valids and FIFO entries are invalidated, and rsp_valid is forced to 0 combinationally.
  - A request presented in the flush cycle is accepted and becomes the only outstanding entry (count = 1). This request is the redirect target.
  - A pop in the flush cycle has no effect.
- Loader:
  - Writes the array at the clock edge.
  - A read of the same word in the same cycle returns the old data (read-first).
  - The loader may operate concurrently with fetches.
- Width and off-chip rules: rsp_data=0 whenever rsp_err=1. No X may propagate onto outputs after reset.

Decomposition:
- Shared package: fetch fault code constants, the FIFO depth formula (LAT+1), and the clog2 function.
- One natural sub-module: resp_fifo, a synchronous FIFO of depth F and width W+1, with push/pop/flush and count.
- Array and decode logic stay in imem_responder.

Test Plan:
- Back-to-back fetch, LAT=1, BASE=0:
  - Stimulus: load words 0..3 = 32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193; request addresses 0,4,8,C on consecutive cycles with rsp_ready=1.
  - Response: data in order one per cycle starting 1 cycle after the first accept, err=0, req_ready stays 1.
- Backpressure:
  - Stimulus: LAT=2 (F=3), rsp_ready=0, request 4 consecutive addresses.
  - Response: 3 accepted, req_ready=0 on the 4th; head holds word 0 steady. Raise rsp_ready: words 0,1,2 drain in order, then the 4th is accepted.
- Faults:
  - Stimulus: request 32'h00000006, then DEPTH*4 (32'h00001000 at the default DEPTH).
  - Response: both return rsp_err=1 and rsp_data=0, in order, between valid responses.
- Flush with redirect:
  - Stimulus: 2 responses pending and unpopped, then flush=1 with a request to addr 8 in the same cycle.
  - Response: rsp_valid=0 in the flush cycle; the next response is word 2 only; the outstanding count is 1 after the flush cycle.
- Reset mid-operation:
  - Stimulus: FIFO full, then rst=1 for 1 cycle together with ld_we=1.
  - Response: rsp_valid=0, req_ready=1 in the next cycle; the load is dropped; array contents from earlier loads are preserved.
- Loader collision:
  - Stimulus: in the same cycle, fetch addr 0 and ld_we to index 0 with 32'hDEADBEEF.
  - Response: that fetch returns the old word; the next fetch of addr 0 returns 32'hDEADBEEF.
